fc_layer_ctrl: RTL and testbench
================================

Name: fc_layer_ctrl

Overview:
Sequencer for the FC layer. On `start`, it walks the FC weight ROM through addresses 0..N_IN-1 and then reads the bias at address N_IN. In parallel it reads the matching feature word from the pooled-feature buffer and performs N_IN signed MACs plus the bias add. It then applies optional ReLU and saturation and presents one result on a valid/ready output; it sits between the pooling stage buffer and the classifier output.

Parameters:
N_IN, 8, number of FC inputs/weights; the bias sits at ROM address N_IN
ROM_AW, 4, weight ROM address width
FEAT_AW, 3, feature buffer address width
ACC_W, 20, accumulator width (8 x 16-bit products + 16-bit bias cannot overflow)
OUT_W, 16, result width after saturation
RELU_EN, 1, 1 = clamp negative results to 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request one FC evaluation; sampled only in IDLE
busy  out  1  high in every state except IDLE
rom_addr  out  ROM_AW  weight ROM address (ROM has 1-cycle synchronous read)
rom_weight  in  8  signed weight from ROM, valid 1 cycle after rom_addr
rom_bias  in  16  signed bias from ROM, valid 1 cycle after rom_addr = N_IN
feat_addr  out  FEAT_AW  feature buffer address (1-cycle synchronous read)
feat_data  in  8  signed feature, valid 1 cycle after feat_addr
result  out  OUT_W  signed FC output
result_valid  out  1  result available
result_ready  in  1  consumer accepts result

Behaviour:
- Reset, asynchronous and active-low: state=IDLE, cnt=0, acc=0, rd_vld=0, rom_addr=0, feat_addr=0, result=0, result_valid=0, busy=0.
- rom_addr and feat_addr are registered copies of cnt.
  - rom_addr = cnt.
  - feat_addr = cnt[FEAT_AW-1:0]; it holds its last value during the bias issue.
- States: IDLE, RUN, BIAS, OUT.
- IDLE:
  - Transition: start=1 -> RUN with cnt=0, acc=0.
  - start=0 -> stay in IDLE.
- RUN:
  - Each cycle, issue address cnt and increment cnt.
  - After cnt=N_IN is issued -> BIAS.
  - Issue sequence is addr 0..N_IN, i.e. N_IN+1 cycles.
  - rd_vld is a 1-cycle delayed "weight address issued" flag, asserted for cnt<N_IN.
  - When rd_vld=1: acc <= acc + sext(rom_weight*feat_data), using a signed 8x8 -> 16-bit product.
- BIAS (1 cycle):
  - rom_bias is valid in this cycle; this is the last weight data cycle already accumulated.
  - sum = acc + sext(rom_bias).
  - If RELU_EN and sum<0, then sum=0.
  - Saturate to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register the result; result_valid <= 1; -> OUT.
- OUT:
  - Hold result and result_valid stable until result_valid & result_ready.
  - On handshake: result_valid <= 0 -> IDLE.
- Latency: start accepted at edge E0 -> result_valid high after edge E0+N_IN+3, i.e. 11 cycles at N_IN=8.
- start is ignored (no queuing) whenever state != IDLE.
- Back-to-back operation: start may be asserted the cycle after the handshake (IDLE); there is no bubble beyond the IDLE cycle.
- rom_weight is ignored during the bias cycle and rom_bias is ignored during weight cycles; the ROM zeroes the unused output anyway.
- Reset asserted mid-operation: immediate return to IDLE with all registers cleared. No partial result is output; result_valid=0.
- Accumulation uses full precision; saturation is applied only once, at BIAS.

Decomposition:
- Package fc_pkg holds:
  - the state enum (IDLE/RUN/BIAS/OUT);
  - widths WGT_W=8, FEAT_W=8, BIAS_W=16, PROD_W=16;
  - the defaults ACC_W, OUT_W, N_IN;
  - BIAS_ADDR=N_IN.
- One sub-module, fc_out_stage: combinational bias add + ReLU + saturation (ACC_W in, OUT_W out), instantiated by the controller.
- The counter, FSM and MAC stay in fc_layer_ctrl.

Test Plan:
1. All weights +1, bias 0, features 1..8, ready=1 -> addresses 0..8 issued on consecutive cycles; result=36 with result_valid high exactly 11 cycles after start.
2. Weights +1, bias 0, features all -128, RELU_EN=1 -> sum -1024 clamped, result=0; rerun with RELU_EN=0 -> result=-1024.
3. Weights 127, features 127, bias 32767 -> sum 161799, saturated result=32767. Weights -128, features 127, bias -32768, RELU_EN=0 -> result=-32768.
4. Backpressure: result_ready low for 5 cycles after valid, with start pulsed during OUT -> result and result_valid held stable, busy=1, start ignored; handshake -> IDLE, busy=0.
5. Reset mid-RUN (rst_n low when cnt=4) -> outputs cleared asynchronously, state IDLE. A subsequent start with test-1 data -> result=36 (no stale accumulation).
6. Back-to-back: second start one cycle after the first handshake, with bias changed to -6 -> second result=30, latency again 11 cycles.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and default widths for the FC layer sequencer.
//   fc_state_e : controller states (IDLE / RUN / BIAS / OUT)
//   *_W        : operand, product and accumulator widths
//   *_DEF      : default parameter values used by the controller
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_BIAS = 2'd2,
    ST_OUT  = 2'd3
  } fc_state_e;

  localparam int unsigned WGT_W  = 8;
  localparam int unsigned FEAT_W = 8;
  localparam int unsigned BIAS_W = 16;
  localparam int unsigned PROD_W = 16;

  localparam int unsigned N_IN_DEF  = 8;
  localparam int unsigned ACC_W_DEF = 20;
  localparam int unsigned OUT_W_DEF = 16;

  // Bias word sits directly after the last weight in the ROM.
  localparam int unsigned BIAS_ADDR = N_IN_DEF;

endpackage

// File: rtl/fc_out_stage.sv
// Combinational output stage: bias add, optional ReLU, signed saturation.
//   acc_i      : accumulated dot product (signed, ACC_W)
//   bias_i     : bias word from ROM (signed, BIAS_W)
//   result_c_o : saturated result (signed, OUT_W), combinational
module fc_out_stage
  import fc_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [BIAS_W-1:0] bias_i,
  output logic signed [OUT_W-1:0]  result_c_o
);

  // One guard bit so the bias add itself can never wrap.
  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [SUM_W-1:0] sum_c;

  // Bias add, then ReLU clamp, then saturate to the output range.
  always_comb begin
    sum_c = SUM_W'(acc_i) + SUM_W'(bias_i);
    if (RELU_EN && sum_c[SUM_W-1]) begin
      result_c_o = '0;
    end else if (sum_c > SAT_MAX) begin
      result_c_o = SAT_MAX[OUT_W-1:0];
    end else if (sum_c < SAT_MIN) begin
      result_c_o = SAT_MIN[OUT_W-1:0];
    end else begin
      result_c_o = sum_c[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fc_layer_ctrl.sv
// FC layer sequencer: walks the weight ROM (addresses 0..N_IN, bias last),
// reads matching features, accumulates N_IN signed MACs, adds the bias,
// applies ReLU/saturation and hands one result out on valid/ready.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : request one evaluation (sampled in IDLE only)
//   busy             : high whenever the sequencer is not idle
//   rom_addr         : weight ROM address (1-cycle synchronous read)
//   rom_weight       : signed weight, valid one cycle after rom_addr
//   rom_bias         : signed bias, valid one cycle after rom_addr = N_IN
//   feat_addr        : feature buffer address (1-cycle synchronous read)
//   feat_data        : signed feature, valid one cycle after feat_addr
//   result           : signed saturated FC output
//   result_valid     : result available
//   result_ready     : consumer accepts result
module fc_layer_ctrl
  import fc_pkg::*;
#(
  parameter int unsigned N_IN    = N_IN_DEF,
  parameter int unsigned ROM_AW  = 4,
  parameter int unsigned FEAT_AW = 3,
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [WGT_W-1:0]    rom_weight,
  input  logic [BIAS_W-1:0]   rom_bias,
  output logic [FEAT_AW-1:0]  feat_addr,
  input  logic [FEAT_W-1:0]   feat_data,
  output logic [OUT_W-1:0]    result,
  output logic                result_valid,
  input  logic                result_ready
);

  // cnt runs 0..N_IN+1: addresses are issued for 0..N_IN, the extra step
  // lets the bias word come back from the ROM before entering BIAS.
  localparam logic [ROM_AW-1:0] CNT_BIAS = ROM_AW'(N_IN);
  localparam logic [ROM_AW-1:0] CNT_LAST = ROM_AW'(N_IN + 1);

  fc_state_e                 state_q, state_d;
  logic [ROM_AW-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      rd_vld_q, rd_vld_d;
  logic [ROM_AW-1:0]         rom_addr_q, rom_addr_d;
  logic [FEAT_AW-1:0]        feat_addr_q, feat_addr_d;
  logic [OUT_W-1:0]          result_q, result_d;
  logic                      result_valid_q, result_valid_d;
  logic                      busy_q;

  logic signed [PROD_W-1:0]  wgt_ext_c, feat_ext_c, prod_c;
  logic signed [OUT_W-1:0]   sat_c;

  // Signed 8x8 product; extend operands first so the product is exact.
  always_comb begin
    wgt_ext_c  = PROD_W'($signed(rom_weight));
    feat_ext_c = PROD_W'($signed(feat_data));
    prod_c     = wgt_ext_c * feat_ext_c;
  end

  fc_out_stage #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .RELU_EN (RELU_EN)
  ) u_out_stage (
    .acc_i      (acc_q),
    .bias_i     (rom_bias),
    .result_c_o (sat_c)
  );

  // Next-state, address issue and MAC.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    rd_vld_d       = 1'b0;
    rom_addr_d     = rom_addr_q;
    feat_addr_d    = feat_addr_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ST_RUN: begin
        if (rd_vld_q) begin
          acc_d = acc_q + ACC_W'(prod_c);
        end
        if (cnt_q <= CNT_BIAS) begin
          rom_addr_d = cnt_q;
        end
        if (cnt_q < CNT_BIAS) begin
          feat_addr_d = FEAT_AW'(cnt_q);
        end
        // A weight address (cnt-1) is on the ROM this cycle, so its data
        // arrives next cycle.
        rd_vld_d = (cnt_q != '0) && (cnt_q <= CNT_BIAS);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_BIAS;
        end else begin
          cnt_d = cnt_q + ROM_AW'(1);
        end
      end
      ST_BIAS: begin
        result_d       = sat_c;
        result_valid_d = 1'b1;
        state_d        = ST_OUT;
      end
      ST_OUT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      acc_q          <= '0;
      rd_vld_q       <= 1'b0;
      rom_addr_q     <= '0;
      feat_addr_q    <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      rd_vld_q       <= rd_vld_d;
      rom_addr_q     <= rom_addr_d;
      feat_addr_q    <= feat_addr_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= (state_d != ST_IDLE);
    end
  end

  assign busy         = busy_q;
  assign rom_addr     = rom_addr_q;
  assign feat_addr    = feat_addr_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Self-checking bench for fc_layer_ctrl: two instances (ReLU on / off)
// share stimulus; results are compared against a plain-arithmetic model.
module tb_fc_layer_ctrl;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;

  always #5 clk = ~clk;

  int w[N];
  int f[N];
  int b;

  int total = 0;
  int bad = 0;

  logic        busy_a, vld_a, busy_b, vld_b;
  logic [3:0]  ra_a, ra_b;
  logic [2:0]  fa_a, fa_b;
  logic [7:0]  rw_a, rw_b, fd_a, fd_b;
  logic [15:0] rb_a, rb_b, res_a, res_b;

  fc_layer_ctrl #(.RELU_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a),
    .rom_addr(ra_a), .rom_weight(rw_a), .rom_bias(rb_a),
    .feat_addr(fa_a), .feat_data(fd_a),
    .result(res_a), .result_valid(vld_a), .result_ready(ready)
  );

  fc_layer_ctrl #(.RELU_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_b),
    .rom_addr(ra_b), .rom_weight(rw_b), .rom_bias(rb_b),
    .feat_addr(fa_b), .feat_data(fd_b),
    .result(res_b), .result_valid(vld_b), .result_ready(ready)
  );

  function automatic logic [7:0] wsel(logic [3:0] a);
    if (a < 4'(N)) return 8'(w[a[2:0]]);
    return 8'h00;
  endfunction

  function automatic logic [15:0] bsel(logic [3:0] a);
    if (a == 4'(N)) return 16'(b);
    return 16'h0000;
  endfunction

  // Synchronous-read ROM and feature buffer models, one per instance.
  always_ff @(posedge clk) begin
    rw_a <= wsel(ra_a);
    rb_a <= bsel(ra_a);
    fd_a <= 8'(f[fa_a]);
    rw_b <= wsel(ra_b);
    rb_b <= bsel(ra_b);
    fd_b <= 8'(f[fa_b]);
  end

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(bit relu);
    int s;
    s = b;
    for (int i = 0; i < N; i++) s += w[i] * f[i];
    if (relu && s < 0) s = 0;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic load_t1();
    for (int i = 0; i < N; i++) begin
      w[i] = 1;
      f[i] = i + 1;
    end
    b = 0;
  endtask

  // Starts at a negedge with ready low; ends at a negedge after the handshake.
  task automatic run_op(string tag, int hold, bit pulse);
    int k;
    int ea, eb, ra, rbv;
    ea = model(1'b1);
    eb = model(1'b0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_run"}, int'(busy_a), 1);
    k = 0;
    while (!vld_a && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k <= N + 1) chk({tag, ".rom_addr"}, int'(ra_a), k - 1);
      if (k <= N) chk({tag, ".feat_addr"}, int'(fa_a), k - 1);
    end
    chk({tag, ".latency"}, k, N + 3);
    chk({tag, ".vld_b"}, int'(vld_b), 1);
    ra  = int'($signed(res_a));
    rbv = int'($signed(res_b));
    chk({tag, ".res_relu"}, ra, ea);
    chk({tag, ".res_norelu"}, rbv, eb);
    for (int i = 0; i < hold; i++) begin
      start = (pulse && i == 1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk({tag, ".hold_res"}, int'($signed(res_a)), ea);
      chk({tag, ".hold_vld"}, int'(vld_a), 1);
      chk({tag, ".hold_busy"}, int'(busy_a), 1);
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    chk({tag, ".vld_after"}, int'(vld_a), 0);
    chk({tag, ".busy_after"}, int'(busy_a), 0);
    chk({tag, ".vld_b_after"}, int'(vld_b), 0);
  endtask

  initial begin
    load_t1();
    repeat (2) @(negedge clk);
    chk("rst.busy", int'(busy_a), 0);
    chk("rst.vld", int'(vld_a), 0);
    chk("rst.rom_addr", int'(ra_a), 0);
    chk("rst.feat_addr", int'(fa_a), 0);
    chk("rst.result", int'(res_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic dot product.
    load_t1();
    run_op("t1", 0, 1'b0);

    // Negative sum: clamped with ReLU, passed through without.
    for (int i = 0; i < N; i++) begin w[i] = 1; f[i] = -128; end
    b = 0;
    run_op("t2", 0, 1'b0);

    // Positive and negative saturation.
    for (int i = 0; i < N; i++) begin w[i] = 127; f[i] = 127; end
    b = 32767;
    run_op("t3p", 0, 1'b0);
    for (int i = 0; i < N; i++) begin w[i] = -128; f[i] = 127; end
    b = -32768;
    run_op("t3n", 0, 1'b0);

    // Backpressure with an ignored start pulse during OUT.
    load_t1();
    run_op("t4", 5, 1'b1);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("t4.idle_busy", int'(busy_a), 0);
    end

    // Reset while running, then a clean evaluation.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("t5.busy", int'(busy_a), 0);
    chk("t5.vld", int'(vld_a), 0);
    chk("t5.rom_addr", int'(ra_a), 0);
    chk("t5.feat_addr", int'(fa_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("t5", 0, 1'b0);

    // Back-to-back evaluations with no idle gap beyond the IDLE cycle.
    load_t1();
    run_op("t6a", 0, 1'b0);
    b = -6;
    run_op("t6b", 0, 1'b0);

    // Randomized data and backpressure.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < N; i++) begin
        w[i] = int'($signed(8'($urandom)));
        f[i] = int'($signed(8'($urandom)));
      end
      b = int'($signed(16'($urandom)));
      run_op("rnd", int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
